// File: rtl/writeback_unit_pkg.sv
// -----------------------------------------------------------------------------
// writeback_unit_pkg
// Shared constants, state encoding and helpers for the writeback unit.
//   WB_DEPTH  : entries in the in-order request FIFO
//   REG_COUNT : number of architectural registers (valid indices 1..31)
//   DATA_W    : register data width
//   ADDR_W    : width of request / query addresses
// -----------------------------------------------------------------------------
package writeback_unit_pkg;

   localparam int WB_DEPTH  = 4;
   localparam int REG_COUNT = 32;
   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 12;

   localparam int IDX_W = 5;   // register-file index width
   localparam int CNT_W = 3;   // FIFO occupancy / pending count width (0..5)
   localparam int PTR_W = 2;   // FIFO slot index width

   localparam logic [CNT_W-1:0] CNT_ZERO  = 3'd0;
   localparam logic [CNT_W-1:0] CNT_ONE   = 3'd1;
   localparam logic [CNT_W-1:0] CNT_DEPTH = 3'd4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } wb_state_e;

   // An address names a writable register only if it is in 1..REG_COUNT-1;
   // register 0 and anything beyond the file are never written or forwarded.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a != {ADDR_W{1'b0}}) && (a < ADDR_W'(REG_COUNT));
   endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// -----------------------------------------------------------------------------
// writeback_unit_if
// Bundles the request, register-file and forwarding-query signals of the
// writeback unit. The slave modport is the unit's view, master the driver's.
//   in_valid/in_ready/in_addr/in_data : request handshake
//   rf_we/rf_waddr/rf_wdata/rf_ready  : register-file write port
//   q_addr/q_hit/q_data               : forwarding query (active only when
//                                       WB_FORWARD_EN is defined)
//   drop_pulse                        : request discarded for a bad address
//   pending                           : writes accepted but not committed
// -----------------------------------------------------------------------------
interface writeback_unit_if;
   import writeback_unit_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [ADDR_W-1:0]    in_addr;
   logic [DATA_W-1:0]    in_data;
   logic                 rf_we;
   logic [IDX_W-1:0]     rf_waddr;
   logic [DATA_W-1:0]    rf_wdata;
   logic                 rf_ready;
   logic [ADDR_W-1:0]    q_addr;
   logic                 q_hit;
   logic [DATA_W-1:0]    q_data;
   logic                 drop_pulse;
   logic [CNT_W-1:0]     pending;

   modport slave (
      input  in_valid, in_addr, in_data, rf_ready, q_addr,
      output in_ready, rf_we, rf_waddr, rf_wdata, q_hit, q_data, drop_pulse, pending
   );

   modport master (
      output in_valid, in_addr, in_data, rf_ready, q_addr,
      input  in_ready, rf_we, rf_waddr, rf_wdata, q_hit, q_data, drop_pulse, pending
   );

endinterface

// File: rtl/writeback_unit_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// In-order request FIFO built as a shift register: slot 0 is always the head
// and valid slots are contiguous, so the highest valid slot is the newest.
//   clk, rst        : clock, asynchronous active-high reset
//   i_push/i_pop    : enqueue at tail / dequeue head (both allowed together)
//   i_push_idx/data : entry being enqueued
//   o_head_idx/data : current head entry
//   o_empty/o_full  : occupancy flags, o_count the occupancy
//   o_ent_*         : every slot's contents and valid bit for searching
// -----------------------------------------------------------------------------
module wb_fifo
   import writeback_unit_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_push,
   input  logic [IDX_W-1:0]                i_push_idx,
   input  logic [DATA_W-1:0]               i_push_data,
   input  logic                            i_pop,
   output logic [IDX_W-1:0]                o_head_idx,
   output logic [DATA_W-1:0]               o_head_data,
   output logic                            o_empty,
   output logic                            o_full,
   output logic [CNT_W-1:0]                o_count,
   output logic [WB_DEPTH-1:0]             o_ent_valid,
   output logic [WB_DEPTH-1:0][IDX_W-1:0]  o_ent_idx,
   output logic [WB_DEPTH-1:0][DATA_W-1:0] o_ent_data
);

   logic [WB_DEPTH-1:0][IDX_W-1:0]  r_idx;
   logic [WB_DEPTH-1:0][DATA_W-1:0] r_data;
   logic [CNT_W-1:0]                r_count;

   logic [WB_DEPTH-1:0][IDX_W-1:0]  w_idx_n;
   logic [WB_DEPTH-1:0][DATA_W-1:0] w_data_n;
   logic [CNT_W-1:0]                w_count_n;

   // Next contents: shift down on pop, then place a push at the new tail.
   always_comb begin
      w_idx_n   = r_idx;
      w_data_n  = r_data;
      w_count_n = r_count;
      if (i_pop && (r_count != CNT_ZERO)) begin
         for (int i = 0; i < WB_DEPTH - 1; i++) begin
            w_idx_n[i]  = r_idx[i+1];
            w_data_n[i] = r_data[i+1];
         end
         w_idx_n[WB_DEPTH-1]  = {IDX_W{1'b0}};
         w_data_n[WB_DEPTH-1] = {DATA_W{1'b0}};
         w_count_n            = r_count - CNT_ONE;
      end else begin
         w_count_n = r_count;
      end
      if (i_push && (w_count_n < CNT_DEPTH)) begin
         w_idx_n[w_count_n[PTR_W-1:0]]  = i_push_idx;
         w_data_n[w_count_n[PTR_W-1:0]] = i_push_data;
         w_count_n                      = w_count_n + CNT_ONE;
      end else begin
         w_count_n = w_count_n;
      end
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= {(WB_DEPTH*IDX_W){1'b0}};
         r_data  <= {(WB_DEPTH*DATA_W){1'b0}};
         r_count <= CNT_ZERO;
      end else begin
         r_idx   <= w_idx_n;
         r_data  <= w_data_n;
         r_count <= w_count_n;
      end
   end

   // Slot i holds a live entry when it lies below the occupancy count.
   always_comb begin
      o_ent_valid = {WB_DEPTH{1'b0}};
      for (int i = 0; i < WB_DEPTH; i++) begin
         o_ent_valid[i] = (CNT_W'(i) < r_count);
      end
   end

   assign o_head_idx  = r_idx[0];
   assign o_head_data = r_data[0];
   assign o_empty     = (r_count == CNT_ZERO);
   assign o_full      = (r_count == CNT_DEPTH);
   assign o_count     = r_count;
   assign o_ent_idx   = r_idx;
   assign o_ent_data  = r_data;

endmodule

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
// Queues ALU results in a 4-entry in-order FIFO and issues them one at a time
// through an output register to the register-file write port. Requests to
// register 0 or beyond the file are dropped with a one-cycle drop_pulse.
// Ports:
//   clk  : clock (rising edge)
//   rst  : asynchronous active-high reset; pending writes are lost
//   bus  : writeback_unit_if.slave (request, register-file, query, status)
// Configuration:
//   WB_FORWARD_EN : when defined, q_hit/q_data search the FIFO and output
//                   register for the newest pending write to q_addr; when
//                   undefined both are tied to zero.
// -----------------------------------------------------------------------------
module writeback_unit
   import writeback_unit_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   writeback_unit_if.slave    bus
);

   wb_state_e           r_state;
   wb_state_e           w_state_n;
   logic [IDX_W-1:0]    r_waddr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_rdy_en;
   logic                r_drop;

   logic                w_accept, w_good, w_bad, w_push, w_pop, w_load, w_bypass;
   logic [IDX_W-1:0]    w_load_idx;
   logic [DATA_W-1:0]   w_load_data;
   logic [IDX_W-1:0]    w_head_idx;
   logic [DATA_W-1:0]   w_head_data;
   logic                w_empty, w_full;
   logic [CNT_W-1:0]    w_count;
   logic [WB_DEPTH-1:0]             w_ent_valid;
   logic [WB_DEPTH-1:0][IDX_W-1:0]  w_ent_idx;
   logic [WB_DEPTH-1:0][DATA_W-1:0] w_ent_data;
   logic                w_hit;
   logic [DATA_W-1:0]   w_qdata;

   // in_ready depends only on FIFO fullness, never on a same-cycle pop.
   assign bus.in_ready = r_rdy_en & ~w_full;
   assign w_accept     = bus.in_valid & bus.in_ready;
   assign w_good       = w_accept & addr_ok(bus.in_addr);
   assign w_bad        = w_accept & ~addr_ok(bus.in_addr);
   assign w_push       = w_good & ~w_bypass;

   wb_fifo u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_idx  (bus.in_addr[IDX_W-1:0]),
      .i_push_data (bus.in_data),
      .i_pop       (w_pop),
      .o_head_idx  (w_head_idx),
      .o_head_data (w_head_data),
      .o_empty     (w_empty),
      .o_full      (w_full),
      .o_count     (w_count),
      .o_ent_valid (w_ent_valid),
      .o_ent_idx   (w_ent_idx),
      .o_ent_data  (w_ent_data)
   );

   // Next state and output-register load. An idle unit with an empty FIFO
   // takes a good request straight into the output register so rf_we can
   // assert the cycle after acceptance.
   always_comb begin
      w_state_n   = r_state;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_bypass    = 1'b0;
      w_load_idx  = r_waddr;
      w_load_data = r_wdata;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_load      = 1'b1;
               w_load_idx  = w_head_idx;
               w_load_data = w_head_data;
               w_state_n   = ST_WRITE;
            end else if (w_good) begin
               w_bypass    = 1'b1;
               w_load      = 1'b1;
               w_load_idx  = bus.in_addr[IDX_W-1:0];
               w_load_data = bus.in_data;
               w_state_n   = ST_WRITE;
            end else begin
               w_state_n   = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (bus.rf_ready) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_load      = 1'b1;
                  w_load_idx  = w_head_idx;
                  w_load_data = w_head_data;
                  w_state_n   = ST_WRITE;
               end else begin
                  w_state_n   = ST_IDLE;
               end
            end else begin
               w_state_n = ST_WRITE;
            end
         end
         default: begin
            w_state_n = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_n;
      end
   end

   // Output register: holds rf_waddr/rf_wdata until the write is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_waddr <= {IDX_W{1'b0}};
         r_wdata <= {DATA_W{1'b0}};
      end else if (w_load) begin
         r_waddr <= w_load_idx;
         r_wdata <= w_load_data;
      end else begin
         r_waddr <= r_waddr;
         r_wdata <= r_wdata;
      end
   end

   // Ready enable (first cycle after reset release) and drop strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdy_en <= 1'b0;
         r_drop   <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         r_drop   <= w_bad;
      end
   end

   assign bus.rf_we      = (r_state == ST_WRITE);
   assign bus.rf_waddr   = r_waddr;
   assign bus.rf_wdata   = r_wdata;
   assign bus.drop_pulse = r_drop;
   assign bus.pending    = w_count + ((r_state == ST_WRITE) ? CNT_ONE : CNT_ZERO);

`ifdef WB_FORWARD_EN
   // Forwarding search: the output register is the oldest pending write, and
   // higher FIFO slots are newer, so later matches override earlier ones.
   always_comb begin
      w_hit   = 1'b0;
      w_qdata = {DATA_W{1'b0}};
      if (addr_ok(bus.q_addr)) begin
         if ((r_state == ST_WRITE) && (r_waddr == bus.q_addr[IDX_W-1:0])) begin
            w_hit   = 1'b1;
            w_qdata = r_wdata;
         end else begin
            w_hit   = 1'b0;
         end
         for (int i = 0; i < WB_DEPTH; i++) begin
            if (w_ent_valid[i] && (w_ent_idx[i] == bus.q_addr[IDX_W-1:0])) begin
               w_hit   = 1'b1;
               w_qdata = w_ent_data[i];
            end else begin
               w_hit   = w_hit;
            end
         end
      end else begin
         w_hit = 1'b0;
      end
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{bus.q_addr, w_ent_valid, w_ent_idx, w_ent_data};
   assign w_hit        = 1'b0;
   assign w_qdata      = {DATA_W{1'b0}};
`endif

   assign bus.q_hit  = w_hit;
   assign bus.q_data = w_qdata;

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: a writeback request is present.
REQ-004 SHALL have port in_ready, output, 1 bit: the unit can accept a request this cycle.
REQ-005 SHALL have port in_addr, input, 12 bits: destination register address.
REQ-006 SHALL have port in_data, input, 16 bits: value to write (ALU result).
REQ-007 SHALL have port rf_we, output, 1 bit: register-file write strobe.
REQ-008 SHALL have port rf_waddr, output, 5 bits: register-file write index.
REQ-009 SHALL have port rf_wdata, output, 16 bits: register-file write data.
REQ-010 SHALL have port rf_ready, input, 1 bit: the register-file port accepts the write this cycle.
REQ-011 SHALL have port q_addr, input, 12 bits: forwarding query address from the fetch stage.
REQ-012 SHALL have port q_hit, output, 1 bit: a pending write to q_addr exists.
REQ-013 SHALL have port q_data, output, 16 bits: the newest pending value for q_addr.
REQ-014 SHALL have port drop_pulse, output, 1 bit: a request was discarded as invalid.
REQ-015 SHALL have port pending, output, 3 bits: number of writes not yet committed (0..5).

Function
REQ-016 SHALL hold accepted requests in a 4-entry in-order FIFO followed by a 1-entry output register driving rf_*.
REQ-017 SHALL accept a request when in_valid and in_ready are both high; in_ready SHALL be low exactly when the FIFO is full, regardless of any pop in the same cycle.
REQ-018 SHALL discard an accepted request whose in_addr is 0 or at least 32, raising drop_pulse for one cycle, with no FIFO entry created.
REQ-019 SHALL use a two-state machine: IDLE (rf_we=0) and WRITE (rf_we=1, rf_waddr/rf_wdata stable until the write is accepted).
REQ-020 IDLE->WRITE: when the FIFO is non-empty, load the head into the output register and pop it; the earliest rf_we is the cycle after acceptance into an empty unit.
REQ-021 WRITE with rf_ready=1: the write commits; if the FIFO is non-empty, load the next head (back-to-back writes, one per cycle), else go to IDLE.
REQ-022 WRITE with rf_ready=0: hold all rf_* outputs unchanged.
REQ-023 Writes SHALL commit in acceptance order, with no coalescing of same-address requests.
REQ-024 pending SHALL equal FIFO occupancy plus 1 when in WRITE.
REQ-025 q_hit/q_data SHALL be combinational: match on address bits [4:0] against valid FIFO entries and the output register; the newest FIFO match wins, then the output register; q_addr 0 or at least 32 SHALL never hit.
REQ-026 A request accepted in the same cycle as a query SHALL NOT be visible to that query.

Reset
REQ-027 Asserting rst SHALL immediately clear the FIFO and output register, force IDLE, and drive rf_we=0, rf_waddr=0, rf_wdata=0, q_hit=0, q_data=0, drop_pulse=0, pending=0, in_ready=0.
REQ-028 in_ready SHALL rise in the first cycle after rst deasserts; writes pending at reset SHALL be lost and never issued.

Configuration
REQ-029 With macro WB_FORWARD_EN defined, forwarding per REQ-025 SHALL be built; without it, q_hit and q_data SHALL be tied to 0 and no comparators SHALL be synthesized.

Structure
REQ-030 A shared package SHALL hold WB_DEPTH=4, REG_COUNT=32, DATA_W=16, ADDR_W=12, and the two-value state enum.
REQ-031 The FIFO SHALL be a sub-module wb_fifo exposing entry contents and per-entry valid bits for the forwarding search.

Verification
REQ-032 Single write: push addr 0x005, data 0xBEEF into an idle unit with rf_ready=1 -> rf_we high for exactly one cycle, one cycle later, with waddr 5 and wdata 0xBEEF.
REQ-033 Backpressure: rf_ready=0 and 5 pushes -> in_ready low after the 5th push, pending=5; then rf_ready=1 -> 5 consecutive rf_we cycles in push order.
REQ-034 Forwarding: pending writes to addr 3 of 0x1111 then 0x2222, q_addr=3 -> q_hit=1, q_data=0x2222; q_addr=4 -> q_hit=0.
REQ-035 Invalid addresses: push addr 0 and addr 0x040 -> drop_pulse for each, no rf_we, pending unchanged.
REQ-036 Reset mid-operation: 3 pending writes with rf_ready=0, pulse rst asynchronously between clock edges -> rf_we=0 and pending=0 immediately; no write issued after release.
